// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock enable, x/y counters, registered sync/active decode.
// Define VGA_TIMING_FRAME_COUNT_EN to build the frame counter; otherwise frame_count is 0.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        pix_ce,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        hsync_pin,
    output logic        vsync_pin,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV == 0 || CLK_DIV > 16) begin : g_div_check
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_ON    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_OFF   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_ON    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_OFF   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       tick;
    logic       pix_ce_q, active_q, hsync_q, vsync_q, line_start_q, frame_start_q;
    logic       active_d, hsync_d, vsync_d, line_start_d, frame_start_d;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? 4'd0 : div_q + 4'd1;
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Decode from next-state counters so the registered flags line up with x/y.
        active_d      = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
        hsync_d       = ({1'b0, x_d} >= HS_ON) && ({1'b0, x_d} < HS_OFF);
        vsync_d       = ({1'b0, y_d} >= VS_ON) && ({1'b0, y_d} < VS_OFF);
        line_start_d  = tick && (x_d == 10'd0);
        frame_start_d = line_start_d && (y_d == 10'd0);
    end

    // Reset parks on the last pixel of a frame so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            pix_ce_q      <= 1'b0;
            active_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_ce_q      <= tick;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hsync_pin   = hsync_q ^ ~SYNC_POL;
    assign vsync_pin   = vsync_q ^ ~SYNC_POL;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fcount_q;
    logic        first_seen_q;

    // The first frame_start after reset only arms the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcount_q     <= '0;
            first_seen_q <= 1'b0;
        end else if (frame_start_d) begin
            if (first_seen_q) begin
                fcount_q <= fcount_q + 16'd1;
            end
            first_seen_q <= 1'b1;
        end
    end

    assign frame_count = fcount_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two DUTs (CLK_DIV 1 and 4, both sync polarities) checked every cycle
// against an arithmetic raster model indexed by clock edges since reset release.
module tb_vga_timing_gen;

    localparam int unsigned HA = 20, HFP = 3, HS = 5, HBP = 4;
    localparam int unsigned VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam int unsigned FR = HT * VT;
    localparam int unsigned NCYC = 10000;

    typedef struct packed {
        logic        pix_ce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        active;
        logic        hsync;
        logic        vsync;
        logic        hpin;
        logic        vpin;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    obs_t a1, a4;
    obs_t q1[$];
    obs_t q4[$];
    int   vectors = 0;
    int   miscompares = 0;

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .pix_ce(a1.pix_ce), .x(a1.x), .y(a1.y),
        .active(a1.active), .hsync(a1.hsync), .vsync(a1.vsync), .hsync_pin(a1.hpin),
        .vsync_pin(a1.vpin), .line_start(a1.ls), .frame_start(a1.fs), .frame_count(a1.fc)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .pix_ce(a4.pix_ce), .x(a4.x), .y(a4.y),
        .active(a4.active), .hsync(a4.hsync), .vsync(a4.vsync), .hsync_pin(a4.hpin),
        .vsync_pin(a4.vpin), .line_start(a4.ls), .frame_start(a4.fs), .frame_count(a4.fc)
    );

    // n = rising edges seen with reset_n high since the last reset.
    function automatic obs_t model(int unsigned n, int unsigned div, bit pol);
        obs_t        e;
        int unsigned ticks, pos, xi, yi;
        ticks    = n / div;
        e.pix_ce = (n != 0) && (n % div == 0);
        if (ticks == 0) begin
            xi   = HT - 1;
            yi   = VT - 1;
            e.fc = 16'd0;
        end else begin
            pos  = (ticks - 1) % FR;
            xi   = pos % HT;
            yi   = pos / HT;
            e.fc = 16'((ticks - 1) / FR);
        end
`ifndef VGA_TIMING_FRAME_COUNT_EN
        e.fc = 16'd0;
`endif
        e.x      = 10'(xi);
        e.y      = 10'(yi);
        e.active = (xi < HA) && (yi < VA);
        e.hsync  = (xi >= HA + HFP) && (xi < HA + HFP + HS);
        e.vsync  = (yi >= VA + VFP) && (yi < VA + VFP + VS);
        e.hpin   = pol ? e.hsync : ~e.hsync;
        e.vpin   = pol ? e.vsync : ~e.vsync;
        e.ls     = e.pix_ce && (xi == 0);
        e.fs     = e.ls && (yi == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input string f, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s at %0t: got %0h expected %0h", tag, f, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input obs_t a, input obs_t e);
        chk(tag, "pix_ce", 16'(a.pix_ce), 16'(e.pix_ce));
        chk(tag, "x", 16'(a.x), 16'(e.x));
        chk(tag, "y", 16'(a.y), 16'(e.y));
        chk(tag, "active", 16'(a.active), 16'(e.active));
        chk(tag, "hsync", 16'(a.hsync), 16'(e.hsync));
        chk(tag, "vsync", 16'(a.vsync), 16'(e.vsync));
        chk(tag, "hsync_pin", 16'(a.hpin), 16'(e.hpin));
        chk(tag, "vsync_pin", 16'(a.vpin), 16'(e.vpin));
        chk(tag, "line_start", 16'(a.ls), 16'(e.ls));
        chk(tag, "frame_start", 16'(a.fs), 16'(e.fs));
        chk(tag, "frame_count", a.fc, e.fc);
    endtask

    always @(negedge clk) begin
        if (q1.size() != 0) chk_all("div1", a1, q1.pop_front());
        if (q4.size() != 0) chk_all("div4", a4, q4.pop_front());
    end

    initial begin
        int unsigned n;
        int unsigned hold;
        bit          did_mid;
        obs_t        m;
        reset_n = 1'b0;
        n       = 0;
        hold    = 2;
        did_mid = 1'b0;
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            if (reset_n) n++;
            else n = 0;
            if (!reset_n) begin
                if (hold == 0) reset_n = 1'b1;
                else hold--;
            end else begin
                m = model(n, 1, 1'b0);
                // Directed: hit reset while the CLK_DIV=1 raster sits in hsync and vsync.
                if (!did_mid && n > FR && m.hsync && m.vsync) begin
                    did_mid = 1'b1;
                    reset_n = 1'b0;
                    hold    = 1;
                    n       = 0;
                end else if (i > 6000 && $urandom_range(0, 2999) == 0) begin
                    reset_n = 1'b0;
                    hold    = $urandom_range(0, 2);
                    n       = 0;
                end
            end
            q1.push_back(model(n, 1, 1'b0));
            q4.push_back(model(n, 4, 1'b1));
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tb", "directed_reset_hit", 16'(did_mid), 16'd1);
        chk("tb", "queue_drained", 16'(q1.size() + q4.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster timing that drives the noise/test-pattern stage: horizontal and vertical counters, sync pulses, active-video window and pixel-rate clock enable. It sits directly upstream of the colour/noise generator. That stage consumes `hsync` as its line-synchronisation reset and `vsync` as its pause-reseed strobe. Sync outputs here are internal active-high pulses; pin polarity is selected separately.

## Interface
Parameters:
- `CLK_DIV`, 1 — `clk` cycles per pixel, 1..16.
- `H_ACTIVE`, 640 — visible pixels per line.
- `H_FP`, 16 — horizontal front porch, pixels.
- `H_SYNC`, 96 — hsync width, pixels.
- `H_BP`, 48 — horizontal back porch, pixels.
- `V_ACTIVE`, 480 — visible lines.
- `V_FP`, 10 — vertical front porch, lines.
- `V_SYNC`, 2 — vsync width, lines.
- `V_BP`, 33 — vertical back porch, lines.
- `SYNC_POL`, 0 — pin polarity for `hsync_pin`/`vsync_pin`; 0 means active-low.

Ports:
- `clk` in 1 — system clock, rising edge.
- `reset_n` in 1 — reset, asynchronous assert, active-low.
- `pix_ce` out 1 — one-`clk` pixel enable.
- `x` out 10 — horizontal counter, 0..H_TOTAL-1.
- `y` out 10 — vertical counter, 0..V_TOTAL-1.
- `active` out 1 — high while x<H_ACTIVE and y<V_ACTIVE.
- `hsync` out 1 — internal hsync, active-high.
- `vsync` out 1 — internal vsync, active-high.
- `hsync_pin` out 1 — `hsync` XOR ~SYNC_POL.
- `vsync_pin` out 1 — `vsync` XOR ~SYNC_POL.
- `line_start` out 1 — one-`clk` pulse when x becomes 0.
- `frame_start` out 1 — one-`clk` pulse when (x,y) becomes (0,0).
- `frame_count` out 16 — frames since reset (see Configuration).

## Operation
- Totals and widths:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is the same sum of the V_ parameters.
  - Both totals are ≤1024. Exceeding this is a configuration error, flagged by an elaboration-time check.
- Divider:
  - 4-bit `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_ce` is registered high for the one cycle in which `div` = 0 after wrap.
  - CLK_DIV=1 gives `pix_ce` constantly high after reset.
- Counter advance, on each `pix_ce`:
  - x increments.
  - At x=H_TOTAL-1, x wraps to 0 and y increments.
  - At y=V_TOTAL-1 with x wrapping, y wraps to 0.
- Decode windows:
  - `hsync` is high for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - `vsync` is high for V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (default 490..491). It is line-granular and spans whole lines, independent of x.
- Registered decode: every decoded output is computed from the next-state counters and registered. `active`, `hsync` and `vsync` therefore always match the current `x`/`y` with zero skew.
- Reset, asynchronous on `reset_n` low:
  - Counters: x=H_TOTAL-1, y=V_TOTAL-1, div=0.
  - Decoded outputs: `pix_ce`=0, `active`=0, `hsync`=0, `vsync`=0, `line_start`=0, `frame_start`=0, `frame_count`=0.
  - Pins: `hsync_pin`/`vsync_pin` at inactive level.
  - The reset state is the last pixel of a frame, so the first `pix_ce` after release wraps to (0,0) with `frame_start`=1 and `active`=1.
- Release: deassertion is taken synchronously. The first `pix_ce` occurs CLK_DIV cycles after the first rising edge with `reset_n` high.
- Reset mid-frame returns to the reset state immediately, with no partial sync pulse held.

## Timing
- `line_start` and `frame_start` are asserted in the same cycle as the `pix_ce` whose edge produced x=0 (and y=0). Each lasts exactly one `clk`.
- Latency from counter change to decode: 0 cycles. Outputs change only on `pix_ce` edges.
- Line period: H_TOTAL×CLK_DIV `clk`. Frame period: H_TOTAL×V_TOTAL×CLK_DIV `clk`.
- At frame wrap, `line_start` and `frame_start` are both high in the same cycle.

## Configuration
- `VGA_TIMING_FRAME_COUNT_EN` defined:
  - `frame_count` increments on each `frame_start`, excluding the first one after reset.
  - It wraps modulo 2^16 (65535→0).
- Undefined: `frame_count` is tied to 0 and no counter logic is built. The port exists in both builds.

## Test plan
- Reset, default parameters, CLK_DIV=1: during reset x=799, y=524, all pulses 0. On the first edge after release x=0, y=0, `active`=1, `frame_start`=1, `line_start`=1.
- Free run for one line: `line_start` pulses every 800 `clk`. `hsync` rises at x=656 and falls at x=752 (96 cycles). `active` falls at x=640.
- Run one frame: `frame_start` interval is 420000 `clk`. `vsync` is high for exactly 1600 `clk`, starting at (0,490). `active` is 0 for all y≥480.
- CLK_DIV=4: `pix_ce` period is 4 `clk`. x holds for 4 cycles per value. The frame takes 1680000 `clk`.
- Assert `reset_n` low at (700,491) during hsync and vsync: all outputs return to reset values within the same cycle. After release, timing restarts from (0,0).
- With `VGA_TIMING_FRAME_COUNT_EN`:
  - `frame_count` reads 0 after the first frame_start and N after N+1 frame_starts.
  - Forcing the count to 65535 and running one more frame gives 0.
